// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding, default geometry
// and block-offset helpers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } arb_state_e;

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_MEM_LAT         = 4;

  // Byte-offset bits inside one 16-bit word.
  localparam int BYTE_OFF_W = 1;

  // Byte-offset bits inside one block.
  function automatic int blk_off_w(input int words);
    return $clog2(words) + BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue, receive and read-latency counters for one block fill; held clear while
// the arbiter is idle, so every grant starts from zero.
module mem_arbiter_fill_counter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int MEM_LAT         = DEF_MEM_LAT,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             recv_en,
  output logic [IDX_W-1:0] issue_idx,
  output logic [IDX_W-1:0] recv_idx,
  output logic             issuing,
  output logic             recv_last,
  output logic             recv_ok
);

  localparam int AGE_W = $clog2(MEM_LAT + 1);

  logic [IDX_W:0]   issue_cnt;
  logic [AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      issue_cnt <= '0;
      recv_idx  <= '0;
      age       <= '0;
    end else begin
      if (run && issuing) issue_cnt <= issue_cnt + 1'b1;
      if (run && !recv_ok) age <= age + 1'b1;
      if (recv_en) recv_idx <= recv_idx + 1'b1;
    end
  end

  // Counting one past the last word sets the MSB, which stops issue.
  assign issuing   = ~issue_cnt[IDX_W];
  assign issue_idx = issue_cnt[IDX_W-1:0];
  assign recv_last = (recv_idx == IDX_W'(WORDS_PER_BLOCK - 1));
  // No read of this fill can return before MEM_LAT cycles in; earlier rvalids are leftovers.
  assign recv_ok   = (age == AGE_W'(MEM_LAT));

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between I-cache fills and D-cache fills/write-throughs.
// Optional `ARB_ROUND_ROBIN_EN: ties go to the side not granted last.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int MEM_LAT         = DEF_MEM_LAT,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_word,
  output logic             i_fill_we,
  output logic             d_fill_we,
  output logic             i_done,
  output logic             d_done,
  output logic             busy
);

  localparam int BLK_OFF_W = blk_off_w(WORDS_PER_BLOCK);

  arb_state_e       state, next_state;
  logic             grant_i, grant_d;
  logic             filling, accept;
  logic [15:0]      op_addr, op_wdata;
  logic [IDX_W-1:0] issue_idx, recv_idx;
  logic             issuing, recv_last, recv_ok;

  assign filling = (state == IFILL) || (state == DFILL);
  assign accept  = !rst && filling && mem_rvalid && recv_ok;
  assign busy    = (state != IDLE);

  mem_arbiter_fill_counter #(
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .MEM_LAT        (MEM_LAT)
  ) u_fill_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == IDLE),
    .run      (filling),
    .recv_en  (accept),
    .issue_idx(issue_idx),
    .recv_idx (recv_idx),
    .issuing  (issuing),
    .recv_last(recv_last),
    .recv_ok  (recv_ok)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst) last_d <= 1'b0;
    else if (grant_i || grant_d) last_d <= grant_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end

  // Operand latch: no reset needed, the outputs that use it are gated by state.
  always_ff @(posedge clk) begin
    if (grant_i || grant_d) begin
      op_addr  <= grant_d ? d_addr : i_addr;
      op_wdata <= d_wdata;
    end
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_data  = '0;
    fill_word  = '0;
    i_fill_we  = 1'b0;
    d_fill_we  = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
          if (d_req && (!i_req || !last_d)) grant_d = 1'b1;
          else if (i_req) grant_i = 1'b1;
`else
          if (d_req) grant_d = 1'b1;
          else if (i_req) grant_i = 1'b1;
`endif
          if (grant_d) next_state = d_wr ? DWRITE : DFILL;
          else if (grant_i) next_state = IFILL;
        end
        IFILL, DFILL: begin
          if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = {op_addr[15:BLK_OFF_W], issue_idx, {BYTE_OFF_W{1'b0}}};
          end
          if (accept) begin
            fill_data = mem_rdata;
            fill_word = recv_idx;
            i_fill_we = (state == IFILL);
            d_fill_we = (state == DFILL);
            if (recv_last) begin
              i_done     = (state == IFILL);
              d_done     = (state == DFILL);
              next_state = IDLE;
            end
          end
        end
        DWRITE: begin
          mem_en     = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = op_addr;
          mem_wdata  = op_wdata;
          d_done     = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule
